pulse_gen_multi: RTL and testbench
==================================

// Module: pulse_gen_multi
// PURPOSE
//  N-channel edge-triggered pulse generator; successor to the single-channel fixed-width pulse FSM.
//  Each channel detects a selectable edge on sig[i] and drives pulse[i] high for a run-time programmable
//  number of clock cycles, with optional retrigger. Sits between synchronised inputs and timer/strobe consumers.
// PARAMETERS
//  N_CH     4  number of independent channels
//  WIDTH_W  8  bit width of the pulse-length field (max pulse = 2**WIDTH_W-1 cycles)
// PORTS
//  clock    in   1              system clock, all logic on posedge
//  reset    in   1              asynchronous, active-low reset (reset==0 clears all state immediately)
//  enable   in   N_CH           per-channel enable; 0 = edges ignored, running pulse finishes
//  retrig   in   N_CH           per-channel mode: 1 = retriggerable, 0 = one-shot (edges ignored while busy)
//  edge_sel in   N_CH*2         per-channel edge type: 00 rise, 01 fall, 10 both, 11 none
//  pw       in   N_CH*WIDTH_W   per-channel pulse width in cycles, sampled at trigger
//  sig      in   N_CH           trigger inputs, already synchronous to clock
//  pulse    out  N_CH           registered pulse outputs
//  done     out  N_CH           registered 1-cycle strobe, cycle after last pulse-high cycle
// BEHAVIOUR
//  - Reset: pulse=0, done=0, sig_q=0, cnt=0, state=IDLE for all channels; async assert, sync-free release.
//  - Edge detect: sig_q[i] holds sig[i] from previous posedge; trig = enable & selected edge of (sig_q,sig).
//  - Latency: trig seen at posedge k -> pulse high at k+1..k+pw (exactly pw cycles), low at k+pw+1.
//    Matches property: $rose(sig) |=> pulse[*PW] ##1 !pulse.
//  - done[i] high for exactly one cycle, at k+pw+1 (same cycle pulse falls); never with pulse high.
//  - States per channel: IDLE -> PULSE on trig & pw!=0 (cnt<=pw-1); PULSE: cnt--, PULSE -> IDLE at cnt==0.
//  - pw==0 at trigger: trigger dropped, no pulse, no done.
//  - pw changes while busy: no effect until next trigger (value latched).
//  - Retrig=1, trig in PULSE: cnt reloads pw-1; pulse stays high continuously; done deferred to new end.
//  - Retrig=0, trig in PULSE: ignored. Trig on the final pulse cycle (cnt==0) -> IDLE then no re-trigger.
//  - Retrig=1, trig on final cycle: reload; pulse stays high with no gap, no done emitted.
//  - enable falling mid-pulse: current pulse completes normally with done.
//  - Reset mid-pulse: pulse/done drop asynchronously; post-release edge detect uses sig_q=0 (high sig = rise).
//  - Channels fully independent; simultaneous triggers on all channels handled same cycle.
// CONFIGURATION
//  PULSE_GAP_EN defined: adds state GAP after PULSE; channel stays in GAP (pulse=0) for GAP_CYC
//   cycles (localparam, default 2) before IDLE; triggers during GAP ignored regardless of retrig;
//   done asserted on the first GAP cycle. A retrigger accepted in PULSE still reloads as above.
//  PULSE_GAP_EN undefined: no GAP state; PULSE -> IDLE directly; trigger accepted the cycle after done.
// STRUCTURE
//  - pulse_pkg: typedef enum logic [1:0] {IDLE, PULSE, GAP} pulse_state_t;
//    typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE} edge_sel_t; GAP_CYC constant.
//  - Sub-module pulse_channel (params WIDTH_W): one edge detector + FSM + down counter;
//    pulse_gen_multi is a generate loop of N_CH instances slicing the packed ports.
// TESTING
//  1. Reset low 0-22ns, ch0 rise, pw=5, edge=rise -> pulse[0] high exactly 5 cycles, done[0] 1 cycle after.
//  2. ch1 edge=fall, pw=3, sig 1->0 -> 3-cycle pulse; sig 0->1 produces nothing.
//  3. ch2 retrig=1, pw=4, second rise 2 cycles into pulse -> pulse high 6 cycles total, one done.
//  4. ch3 retrig=0, same stimulus as 3 -> pulse high 4 cycles, second edge ignored, one done.
//  5. pw=0 trigger -> no pulse, no done; reset low mid-pulse (pw=10, cycle 4) -> pulse 0 immediately.
//  6. PULSE_GAP_EN: pw=2, rise at end+1 cycle -> ignored; rise after GAP_CYC cycles -> new 2-cycle pulse.
//  All: SVA per channel "trig |=> pulse[*pw] ##1 !pulse" (non-retrig) and done one-hot-in-time.

Source files
------------

// File: rtl/pulse_gen_multi_pkg.sv
// Shared types for the multi-channel pulse generator: FSM states, edge selection, gap length.
// Optional feature: PULSE_GAP_EN (adds a post-pulse GAP state of GAP_CYC cycles).
package pulse_gen_multi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } pulse_state_t;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_NONE = 2'd3
    } edge_sel_t;

    // Number of dead cycles after a pulse when PULSE_GAP_EN is defined.
    localparam int unsigned GAP_CYC = 2;

    function automatic logic edge_hit(input edge_sel_t sel, input logic prev, input logic cur);
        logic hit;
        unique case (sel)
            EDGE_RISE: hit = !prev && cur;
            EDGE_FALL: hit = prev && !cur;
            EDGE_BOTH: hit = prev != cur;
            EDGE_NONE: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pulse_gen_multi_if.sv
// Packed per-channel control/trigger bus of the pulse generator.
// master drives configuration and triggers; slave (the generator) drives pulse and done.
interface pulse_gen_multi_if #(
    parameter int N_CH    = 4,
    parameter int WIDTH_W = 8
);
    logic [N_CH-1:0]         enable;
    logic [N_CH-1:0]         retrig;
    logic [N_CH*2-1:0]       edge_sel;
    logic [N_CH*WIDTH_W-1:0] pw;
    logic [N_CH-1:0]         sig;
    logic [N_CH-1:0]         pulse;
    logic [N_CH-1:0]         done;

    modport master (
        output enable, retrig, edge_sel, pw, sig,
        input  pulse, done
    );

    modport slave (
        input  enable, retrig, edge_sel, pw, sig,
        output pulse, done
    );
endinterface

// File: rtl/pulse_gen_multi_channel.sv
// One pulse channel: edge detector, IDLE/PULSE(/GAP) FSM and down counter.
// With PULSE_GAP_EN defined, the channel sits in GAP for GAP_CYC cycles after each pulse.
module pulse_gen_multi_channel
    import pulse_gen_multi_pkg::*;
#(
    parameter int WIDTH_W = 8
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic               i_retrig,
    input  edge_sel_t          i_edge_sel,
    input  logic [WIDTH_W-1:0] i_pw,
    input  logic               i_sig,
    output logic               o_pulse,
    output logic               o_done
);

    pulse_state_t       r_state;
    pulse_state_t       w_state_nxt;
    logic [WIDTH_W-1:0] r_cnt;
    logic [WIDTH_W-1:0] w_cnt_nxt;
    logic               r_sig_q;
    logic               r_pulse;
    logic               r_done;
    logic               w_pulse_nxt;
    logic               w_done_nxt;
    logic               w_trig;
    logic               w_load;

    assign w_trig = i_enable && edge_hit(i_edge_sel, r_sig_q, i_sig);
    // A zero-length request is dropped outright rather than producing a pulse.
    assign w_load = w_trig && (i_pw != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; async reset clears all of it immediately.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sig_q <= 1'b0;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sig_q <= i_sig;
            r_pulse <= w_pulse_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults ahead of the case keep this block latch-free.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = i_pw - WIDTH_W'(1);
                end
            end
            PULSE: begin
                if (w_load && i_retrig) begin
                    w_cnt_nxt = i_pw - WIDTH_W'(1);
                end else if (r_cnt == '0) begin
`ifdef PULSE_GAP_EN
                    w_state_nxt = GAP;
                    w_cnt_nxt   = WIDTH_W'(GAP_CYC - 1);
`else
                    w_state_nxt = IDLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - WIDTH_W'(1);
                end
            end
`ifdef PULSE_GAP_EN
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - WIDTH_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // done fires only on a real exit from PULSE, so a retrigger reload defers it.
    always_comb begin
        w_pulse_nxt = (w_state_nxt == PULSE);
        w_done_nxt  = (r_state == PULSE) && (w_state_nxt != PULSE);
    end

    assign o_pulse = r_pulse;
    assign o_done  = r_done;

endmodule

// File: rtl/pulse_gen_multi.sv
// N-channel edge-triggered pulse generator: one independent channel per bit of the bus.
// Optional post-pulse gap enabled with PULSE_GAP_EN.
module pulse_gen_multi
    import pulse_gen_multi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int WIDTH_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    pulse_gen_multi_if.slave bus
);

    logic [N_CH-1:0] w_pulse;
    logic [N_CH-1:0] w_done;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pulse_gen_multi_channel #(
            .WIDTH_W (WIDTH_W)
        ) u_ch (
            .i_clock    (clock),
            .i_reset_n  (reset),
            .i_enable   (bus.enable[g]),
            .i_retrig   (bus.retrig[g]),
            .i_edge_sel (edge_sel_t'(bus.edge_sel[2*g +: 2])),
            .i_pw       (bus.pw[g*WIDTH_W +: WIDTH_W]),
            .i_sig      (bus.sig[g]),
            .o_pulse    (w_pulse[g]),
            .o_done     (w_done[g])
        );
    end

    assign bus.pulse = w_pulse;
    assign bus.done  = w_done;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: per-cycle pulse/done history compared with hand-built patterns.
// Expected patterns for the gap scenario switch on PULSE_GAP_EN.
module tb_pulse_gen_multi;
    import pulse_gen_multi_pkg::*;

    localparam int N_CH    = 4;
    localparam int WIDTH_W = 8;
    localparam int HMAX    = 4096;

    logic clock;
    logic reset;

    pulse_gen_multi_if #(.N_CH(N_CH), .WIDTH_W(WIDTH_W)) bus ();

    pulse_gen_multi #(
        .N_CH    (N_CH),
        .WIDTH_W (WIDTH_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-negedge history of pulse/done, indexed by absolute falling-edge count.
    logic [N_CH-1:0] hist_p [HMAX];
    logic [N_CH-1:0] hist_d [HMAX];
    int ncyc = 0;
    int base = 0;

    always @(negedge clock) begin
        if (ncyc < HMAX) begin
            hist_p[ncyc] <= bus.pulse;
            hist_d[ncyc] <= bus.done;
            ncyc         <= ncyc + 1;
        end
    end

    function automatic logic [15:0] pat(input int ch, input bit want_done);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if (base + i < HMAX) p[i] = want_done ? hist_d[base + i][ch] : hist_p[base + i][ch];
        end
        return p;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_rec();
        base = ncyc;
    endtask

    task automatic set_pw(input int ch, input int val);
        bus.pw[ch*WIDTH_W +: WIDTH_W] = WIDTH_W'(val);
    endtask

    task automatic set_edge(input int ch, input edge_sel_t e);
        bus.edge_sel[2*ch +: 2] = e;
    endtask

    // Output-level sanity on every channel: done never overlaps pulse and lasts one cycle.
    for (genvar i = 0; i < N_CH; i++) begin : g_sva
        a_done_not_pulse: assert property (@(posedge clock) disable iff (!reset)
            !(bus.done[i] && bus.pulse[i]));
        a_done_one_cycle: assert property (@(posedge clock) disable iff (!reset)
            bus.done[i] |=> !bus.done[i]);
    end

    initial begin
        reset        = 1'b0;
        bus.enable   = 4'hF;
        bus.retrig   = 4'b0100;
        bus.sig      = 4'h0;
        bus.edge_sel = '0;
        bus.pw       = '0;
        set_edge(0, EDGE_RISE);
        set_edge(1, EDGE_FALL);
        set_edge(2, EDGE_RISE);
        set_edge(3, EDGE_RISE);
        set_pw(0, 5);
        set_pw(1, 3);
        set_pw(2, 4);
        set_pw(3, 4);

        #20;
        check("rst_pulse", {28'd0, bus.pulse}, 32'd0);
        check("rst_done", {28'd0, bus.done}, 32'd0);
        #2 reset = 1'b1;
        step(1);

        // ch0 rise, pw=5; pw rewritten mid-pulse must not matter
        start_rec();
        bus.sig[0] = 1'b1;
        step(2);
        set_pw(0, 9);
        step(14);
        check("t1_pulse", pat(0, 0), 16'h003E);
        check("t1_done", pat(0, 1), 16'h0040);

        // ch1 falling edge, pw=3; rise ignored; enable dropped mid-pulse
        start_rec();
        bus.sig[1] = 1'b1;
        step(5);
        bus.sig[1] = 1'b0;
        step(2);
        bus.enable[1] = 1'b0;
        step(14);
        bus.enable[1] = 1'b1;
        check("t2_pulse", pat(1, 0), 16'h01C0);
        check("t2_done", pat(1, 1), 16'h0200);

        // ch2 retrig vs ch3 one-shot, second rise 2 cycles into the pulse
        start_rec();
        bus.sig[3:2] = 2'b11;
        step(1);
        bus.sig[3:2] = 2'b00;
        step(1);
        bus.sig[3:2] = 2'b11;
        step(16);
        check("t3_retrig_pulse", pat(2, 0), 16'h007E);
        check("t3_retrig_done", pat(2, 1), 16'h0080);
        check("t4_oneshot_pulse", pat(3, 0), 16'h001E);
        check("t4_oneshot_done", pat(3, 1), 16'h0020);

        // trigger on the final pulse cycle: retrig reloads seamlessly, one-shot ends
        set_pw(2, 2);
        set_pw(3, 2);
        bus.sig[3:2] = 2'b00;
        step(2);
        start_rec();
        bus.sig[3:2] = 2'b11;
        step(1);
        bus.sig[3:2] = 2'b00;
        step(1);
        bus.sig[3:2] = 2'b11;
        step(16);
        check("last_retrig_pulse", pat(2, 0), 16'h001E);
        check("last_retrig_done", pat(2, 1), 16'h0020);
        check("last_oneshot_pulse", pat(3, 0), 16'h0006);
        check("last_oneshot_done", pat(3, 1), 16'h0008);

        // ch3 pw=2 one-shot, rises at offsets 0, 3 and 5
        bus.sig[3] = 1'b0;
        step(2);
        start_rec();
        bus.sig[3] = 1'b1;
        step(1);
        bus.sig[3] = 1'b0;
        step(2);
        bus.sig[3] = 1'b1;
        step(1);
        bus.sig[3] = 1'b0;
        step(1);
        bus.sig[3] = 1'b1;
        step(16);
`ifdef PULSE_GAP_EN
        check("t6_gap_pulse", pat(3, 0), 16'h00C6);
        check("t6_gap_done", pat(3, 1), 16'h0108);
`else
        check("t6_nogap_pulse", pat(3, 0), 16'h0036);
        check("t6_nogap_done", pat(3, 1), 16'h0048);
`endif

        // ch0 both edges, pw=2: fall at offset 0, rise at offset 5
        set_pw(0, 2);
        set_edge(0, EDGE_BOTH);
        step(1);
        start_rec();
        bus.sig[0] = 1'b0;
        step(5);
        bus.sig[0] = 1'b1;
        step(11);
        check("both_pulse", pat(0, 0), 16'h00C6);
        check("both_done", pat(0, 1), 16'h0108);

        // ch0 edge none: nothing at all
        set_edge(0, EDGE_NONE);
        start_rec();
        bus.sig[0] = 1'b0;
        step(2);
        bus.sig[0] = 1'b1;
        step(14);
        check("none_pulse", pat(0, 0), 16'h0000);
        check("none_done", pat(0, 1), 16'h0000);

        // ch0 pw=0: trigger dropped
        set_edge(0, EDGE_RISE);
        set_pw(0, 0);
        bus.sig[0] = 1'b0;
        step(2);
        start_rec();
        bus.sig[0] = 1'b1;
        step(16);
        check("pw0_pulse", pat(0, 0), 16'h0000);
        check("pw0_done", pat(0, 1), 16'h0000);

        // ch0 pw=10, reset asserted on the 4th pulse cycle
        set_pw(0, 10);
        set_pw(2, 4);
        bus.sig[0] = 1'b0;
        step(2);
        start_rec();
        bus.sig[0] = 1'b1;
        step(4);
        check("t5_pre_reset", {31'd0, bus.pulse[0]}, 32'd1);
        #3 reset = 1'b0;
        #1;
        check("t5_async_pulse", {28'd0, bus.pulse}, 32'd0);
        check("t5_async_done", {28'd0, bus.done}, 32'd0);
        step(2);
        // sig held high through reset: release sees it as a fresh rise
        reset = 1'b1;
        start_rec();
        step(16);
        check("post_rst_ch0_pulse", pat(0, 0), 16'h07FE);
        check("post_rst_ch0_done", pat(0, 1), 16'h0800);
        check("post_rst_ch2_pulse", pat(2, 0), 16'h001E);
        check("post_rst_ch2_done", pat(2, 1), 16'h0020);
        check("post_rst_ch1_pulse", pat(1, 0), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
